// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed hex seven-segment driver with shadowed digit data, dp and blank masks.
// Latency: load -> display 1 cycle; index -> an/seg/dp 1 cycle; frame rises with an[0] after each wrap.
// Backpressure: none; load is accepted every cycle and never stalls or restarts the scan.
module seg7_scan #(
    parameter int DIGITS         = 4,
    parameter int DIV            = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LEADING_BLANK  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic [DIGITS-1:0]   blank_in,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
    localparam logic LB_EN   = (LEADING_BLANK != 0);
    localparam logic MULTI   = (DIGITS > 1);

    logic [4*DIGITS-1:0] value_sh;
    logic [DIGITS-1:0]   dp_sh;
    logic [DIGITS-1:0]   blank_sh;
    logic [CW-1:0]       cnt;
    logic                tick;
    logic [IW-1:0]       idx;
    logic                wrap;
    logic                frame_pend;
    logic [DIGITS-1:0]   zero_from;
    logic [3:0]          nib;
    logic                cur_blank;
    logic [6:0]          seg_lit;
    logic                dp_lit;
    logic [DIGITS-1:0]   an_lit;

    // Segment order a..g maps to bits 6..0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h1F;
            4'hC:    s = 7'h4E;
            4'hD:    s = 7'h3D;
            4'hE:    s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_sh <= '0;
            dp_sh    <= '0;
            blank_sh <= '0;
        end else if (load) begin
            value_sh <= value;
            dp_sh    <= dp_in;
            blank_sh <= blank_in;
        end
    end

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= wrap ? '0 : idx + IW'(1);
            end
        end
    end

    // zero_from[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (value_sh[4*DIGITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = (value_sh[4*i +: 4] == 4'h0) && zero_from[i+1];
        end
    end

    assign nib       = value_sh[{idx, 2'b00} +: 4];
    assign cur_blank = blank_sh[idx] | (LB_EN & (idx != '0) & zero_from[idx]);
    assign seg_lit   = cur_blank ? 7'h00 : hex_to_seg(nib);
    assign dp_lit    = ~cur_blank & dp_sh[idx];
    assign an_lit    = cur_blank ? '0 : (DIGITS'(1) << idx);

    // frame is delayed one extra edge so it lines up with an[0] in the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= {7{SEG_INV}};
            dp         <= SEG_INV;
            an         <= {DIGITS{AN_INV}};
            frame_pend <= 1'b0;
            frame      <= 1'b0;
        end else begin
            seg        <= seg_lit ^ {7{SEG_INV}};
            dp         <= dp_lit ^ SEG_INV;
            an         <= an_lit ^ {DIGITS{AN_INV}};
            frame_pend <= wrap & MULTI;
            frame      <= frame_pend;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: three configurations driven by directed vectors; expectations are queued
// per instance and a monitor compares them against the registered outputs.
module tb_seg7_scan;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // A: 4 digits, DIV=3, leading blank, segments active high
    logic        a_rst_n = 1'b0, a_load = 1'b0;
    logic [15:0] a_value = '0;
    logic [3:0]  a_dp_in = '0, a_blank_in = '0;
    logic [6:0]  a_seg;
    logic        a_dp, a_frame;
    logic [3:0]  a_an;
    // B: 1 digit, DIV=1
    logic        b_rst_n = 1'b0, b_load = 1'b0;
    logic [3:0]  b_value = '0;
    logic [0:0]  b_dp_in = '0, b_blank_in = '0;
    logic [6:0]  b_seg;
    logic        b_dp, b_frame;
    logic [0:0]  b_an;
    // C: 4 digits, DIV=3, no leading blank, segments active low
    logic        c_rst_n = 1'b0, c_load = 1'b0;
    logic [15:0] c_value = '0;
    logic [3:0]  c_dp_in = '0, c_blank_in = '0;
    logic [6:0]  c_seg;
    logic        c_dp, c_frame;
    logic [3:0]  c_an;

    seg7_scan #(.DIGITS(4), .DIV(3), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .LEADING_BLANK(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .load(a_load), .value(a_value), .dp_in(a_dp_in),
        .blank_in(a_blank_in), .seg(a_seg), .dp(a_dp), .an(a_an), .frame(a_frame));
    seg7_scan #(.DIGITS(1), .DIV(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .LEADING_BLANK(1)) u_b (
        .clk(clk), .rst_n(b_rst_n), .load(b_load), .value(b_value), .dp_in(b_dp_in),
        .blank_in(b_blank_in), .seg(b_seg), .dp(b_dp), .an(b_an), .frame(b_frame));
    seg7_scan #(.DIGITS(4), .DIV(3), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LEADING_BLANK(0)) u_c (
        .clk(clk), .rst_n(c_rst_n), .load(c_load), .value(c_value), .dp_in(c_dp_in),
        .blank_in(c_blank_in), .seg(c_seg), .dp(c_dp), .an(c_an), .frame(c_frame));

    typedef struct {
        int         at;
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   base = 0;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Expected outputs for digit d of a 4-digit, anode-active-low instance.
    function automatic exp_t mk(input int at, input int n, input int d, input logic [6:0] s,
                                input logic p, input logic b, input logic fr, input logic inv);
        exp_t e;
        e.at  = at;
        e.n   = n;
        e.an  = b ? 4'hF : ~(4'b0001 << d);
        e.seg = (b ? 7'h00 : s) ^ {7{inv}};
        e.dp  = (b ? 1'b0 : p) ^ inv;
        e.fr  = fr;
        return e;
    endfunction

    task automatic check(input string tag, input exp_t e, input logic on_time, input logic [3:0] an,
                         input logic [6:0] s, input logic d, input logic f);
        n_checks++;
        if (!on_time || an !== e.an || s !== e.seg || d !== e.dp || f !== e.fr) begin
            n_fail++;
            $display("FAIL %s[n=%0d] cyc=%0d on_time=%0b: got an=%b seg=%h dp=%b frame=%b, required an=%b seg=%h dp=%b frame=%b",
                     tag, e.n, cyc, on_time, an, s, d, f, e.an, e.seg, e.dp, e.fr);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or negedge c_rst_n);
            #1;
            while (qa.size() > 0 && qa[0].at <= cyc) begin
                e = qa.pop_front();
                check("A", e, e.at == cyc, a_an, a_seg, a_dp, a_frame);
            end
            while (qb.size() > 0 && qb[0].at <= cyc) begin
                e = qb.pop_front();
                check("B", e, e.at == cyc, {3'b000, b_an}, b_seg, b_dp, b_frame);
            end
            while (qc.size() > 0 && qc[0].at <= cyc) begin
                e = qc.pop_front();
                check("C", e, e.at == cyc, c_an, c_seg, c_dp, c_frame);
            end
        end
    end

    task automatic run_a();
        logic [6:0] ts [4];
        logic [6:0] ns [4];
        logic [3:0] tdp, tbk, ndp, nbk;
        logic       ld;
        int         d;
        logic       fr;
        ts  = '{7'h7E, 7'h00, 7'h00, 7'h00};
        tdp = 4'b0000;
        tbk = 4'b1110;
        ns  = ts;
        ndp = tdp;
        nbk = tbk;
        for (int n = 1; n <= 64; n++) begin
            ld = 1'b1;
            case (n)
                1: begin
                    a_value = 16'h1234; a_dp_in = 4'b0000; a_blank_in = 4'b0000;
                    ns = '{7'h33, 7'h79, 7'h6D, 7'h30}; ndp = 4'b0000; nbk = 4'b0000;
                end
                26: begin
                    a_value = 16'h0050; a_dp_in = 4'b0100; a_blank_in = 4'b0000;
                    ns = '{7'h7E, 7'h5B, 7'h7E, 7'h7E}; ndp = 4'b0100; nbk = 4'b1100;
                end
                50: begin
                    a_value = 16'h1234; a_dp_in = 4'b0000; a_blank_in = 4'b0001;
                    ns = '{7'h33, 7'h79, 7'h6D, 7'h30}; ndp = 4'b0000; nbk = 4'b0001;
                end
                56: begin
                    a_value = 16'hABCD; a_dp_in = 4'b0000; a_blank_in = 4'b0001;
                    ns = '{7'h3D, 7'h4E, 7'h1F, 7'h77}; ndp = 4'b0000; nbk = 4'b0001;
                end
                default: ld = 1'b0;
            endcase
            a_load = ld;
            d  = ((n - 1) / 3) % 4;
            fr = (n > 1) && ((n - 1) % 12 == 0);
            qa.push_back(mk(base + n, n, d, ts[d], tdp[d], tbk[d], fr, 1'b0));
            if (ld) begin
                ts  = ns;
                tdp = ndp;
                tbk = nbk;
            end
            @(posedge clk);
            #1;
        end
        a_load = 1'b0;
    endtask

    task automatic run_b();
        exp_t       e;
        logic [6:0] s;
        logic       p;
        for (int n = 1; n <= 19; n++) begin
            b_load = (n <= 16);
            if (n <= 16) begin
                b_value = 4'(n - 1);
                b_dp_in = 1'((n - 1) % 2);
            end
            if (n == 1) begin
                s = 7'h7E; p = 1'b0;
            end else if (n <= 17) begin
                s = seg_tab[n-2]; p = ((n - 2) % 2) == 1;
            end else begin
                s = seg_tab[15]; p = 1'b1;
            end
            e = mk(base + n, n, 0, s, p, 1'b0, 1'b0, 1'b0);
            e.an = 4'b0000;
            qb.push_back(e);
            @(posedge clk);
            #1;
        end
        b_load = 1'b0;
    endtask

    task automatic run_c();
        logic [6:0] ts [4];
        logic [3:0] tdp;
        int         d;
        int         base2;
        ts  = '{7'h7E, 7'h7E, 7'h7E, 7'h7E};
        tdp = 4'b0000;
        for (int n = 1; n <= 7; n++) begin
            c_load = (n == 1);
            if (n == 1) begin
                c_value = 16'h0050; c_dp_in = 4'b0100; c_blank_in = 4'b0000;
            end
            d = ((n - 1) / 3) % 4;
            qc.push_back(mk(base + n, n, d, ts[d], tdp[d], 1'b0, 1'b0, 1'b1));
            if (n == 1) begin
                ts  = '{7'h7E, 7'h5B, 7'h7E, 7'h7E};
                tdp = 4'b0100;
            end
            @(posedge clk);
            #1;
        end
        c_load = 1'b0;
        // Digit 2 is on display; pull reset between clock edges.
        @(negedge clk);
        #2;
        qc.push_back(mk(cyc, 100, 0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1));
        c_rst_n = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            #1;
            qc.push_back(mk(cyc, 100 + k, 0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1));
        end
        c_rst_n = 1'b1;
        base2 = cyc;
        for (int m = 1; m <= 14; m++) begin
            d = ((m - 1) / 3) % 4;
            qc.push_back(mk(base2 + m, 200 + m, d, 7'h7E, 1'b0, 1'b0, m == 13, 1'b1));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        qa.push_back(mk(cyc, 0, 0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        e = mk(cyc, 0, 0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        e.an = 4'b0001;
        qb.push_back(e);
        qc.push_back(mk(cyc, 0, 0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        base    = cyc;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        c_rst_n = 1'b1;
        fork
            run_a();
            run_b();
            run_c();
        join
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0",
                     qa.size() + qb.size() + qc.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
